// File: rtl/katadc_pkg.sv
// Shared types and constants for the KAT ADC synthetic pattern generator.
package katadc_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned LANES    = 4;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_ZERO  = 2'd3;

  localparam logic [SAMPLE_W-1:0] SAT_POS = 8'h7F;
  localparam logic [SAMPLE_W-1:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } state_t;

  // Lane 0 (oldest sample) sits in the least significant byte.
  typedef logic [LANES-1:0][SAMPLE_W-1:0] beat_t;

  function automatic logic is_sat(input logic [SAMPLE_W-1:0] s);
    return (s == SAT_POS) || (s == SAT_NEG);
  endfunction

endpackage

// File: rtl/katadc_pattern_gen_if.sv
// User-side ADC sample bus, identical to the capture block's producer end.
interface katadc_pattern_gen_if;
  import katadc_pkg::*;

  logic [SAMPLE_W-1:0] user_datai0;
  logic [SAMPLE_W-1:0] user_datai1;
  logic [SAMPLE_W-1:0] user_datai2;
  logic [SAMPLE_W-1:0] user_datai3;
  logic [SAMPLE_W-1:0] user_dataq0;
  logic [SAMPLE_W-1:0] user_dataq1;
  logic [SAMPLE_W-1:0] user_dataq2;
  logic [SAMPLE_W-1:0] user_dataq3;
  logic                user_outofrange0;
  logic                user_outofrange1;
  logic                user_sync0;
  logic                user_sync1;
  logic                user_sync2;
  logic                user_sync3;
  logic                user_data_valid;

  modport master (
    output user_datai0, user_datai1, user_datai2, user_datai3,
    output user_dataq0, user_dataq1, user_dataq2, user_dataq3,
    output user_outofrange0, user_outofrange1,
    output user_sync0, user_sync1, user_sync2, user_sync3,
    output user_data_valid
  );

  modport slave (
    input user_datai0, user_datai1, user_datai2, user_datai3,
    input user_dataq0, user_dataq1, user_dataq2, user_dataq3,
    input user_outofrange0, user_outofrange1,
    input user_sync0, user_sync1, user_sync2, user_sync3,
    input user_data_valid
  );

endinterface

// File: rtl/katadc_lfsr4.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advancing four steps per clock.
module katadc_lfsr4
  import katadc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                advance,
  input  logic [SAMPLE_W-1:0] seed,
  output beat_t               lane
);

  logic [SAMPLE_W-1:0] state;

  function automatic logic [SAMPLE_W-1:0] step(input logic [SAMPLE_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always_comb begin
    logic [SAMPLE_W-1:0] s;
    lane = '0;
    s    = state;
    for (int unsigned k = 0; k < LANES; k++) begin
      s       = step(s);
      lane[k] = s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lane[LANES-1];
    end
  end

endmodule

// File: rtl/katadc_pattern_gen.sv
// Synthetic KAT ADC sample source: ramp / constant / LFSR / zero patterns.
// Optional LFSR pattern built only when KATADC_PATGEN_LFSR_EN is defined.
module katadc_pattern_gen
  import katadc_pkg::*;
#(
  parameter int unsigned         ARM_CYCLES  = 16,
  parameter int unsigned         SYNC_PERIOD = 1024,
  parameter int unsigned         SYNC_LANE   = 0,
  parameter logic [SAMPLE_W-1:0] LFSR_SEED   = 8'hA5
) (
  input  logic                   ctrl_clk_in,
  input  logic                   ctrl_reset_n,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [SAMPLE_W-1:0]    const_i,
  input  logic [SAMPLE_W-1:0]    const_q,
  katadc_pattern_gen_if.master   user,
  output logic [31:0]            beat_count
);

  localparam int unsigned       SYNC_W    = (SYNC_PERIOD > 2) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_PERIOD - 1);
  localparam logic [15:0]       ARM_LAST  = 16'(ARM_CYCLES);

  state_t              state;
  logic [15:0]         arm_cnt;
  logic [1:0]          mode_q;
  logic [SAMPLE_W-1:0] ci_q;
  logic [SAMPLE_W-1:0] cq_q;
  logic [SAMPLE_W-1:0] ramp_base;
  logic [SYNC_W-1:0]   sync_cnt;

  beat_t             di_q, dq_q, di_nxt, dq_nxt;
  logic [1:0]        oor_q, oor_nxt;
  logic [LANES-1:0]  sync_q, sync_nxt;
  logic              valid_q;

  logic arm_start;
  logic beat_fire;

  assign arm_start = (state == ST_IDLE) && enable;
  // The ARM->RUN edge also registers beat 0, so valid is high for every RUN cycle.
  assign beat_fire = enable &&
                     (((state == ST_ARM) && (arm_cnt == ARM_LAST)) || (state == ST_RUN));

`ifdef KATADC_PATGEN_LFSR_EN
  beat_t lfsr_i, lfsr_q;

  katadc_lfsr4 u_lfsr_i (
    .clk     (ctrl_clk_in),
    .rst_n   (ctrl_reset_n),
    .load    (arm_start),
    .advance (beat_fire),
    .seed    (LFSR_SEED),
    .lane    (lfsr_i)
  );

  katadc_lfsr4 u_lfsr_q (
    .clk     (ctrl_clk_in),
    .rst_n   (ctrl_reset_n),
    .load    (arm_start),
    .advance (beat_fire),
    .seed    (LFSR_SEED ^ 8'hFF),
    .lane    (lfsr_q)
  );
`endif

  always_comb begin
    logic [SAMPLE_W-1:0] r;
    di_nxt   = '0;
    dq_nxt   = '0;
    sync_nxt = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      r = ramp_base + SAMPLE_W'(k);
      case (mode_q)
        MODE_RAMP: begin
          di_nxt[k] = r;
          dq_nxt[k] = r + 8'h80;
        end
        MODE_CONST: begin
          di_nxt[k] = ci_q;
          dq_nxt[k] = cq_q;
        end
`ifdef KATADC_PATGEN_LFSR_EN
        MODE_LFSR: begin
          di_nxt[k] = lfsr_i[k];
          dq_nxt[k] = lfsr_q[k];
        end
`endif
        default: begin
          di_nxt[k] = '0;
          dq_nxt[k] = '0;
        end
      endcase
    end
    oor_nxt[0] = is_sat(di_nxt[0]) | is_sat(dq_nxt[0]) | is_sat(di_nxt[1]) | is_sat(dq_nxt[1]);
    oor_nxt[1] = is_sat(di_nxt[2]) | is_sat(dq_nxt[2]) | is_sat(di_nxt[3]) | is_sat(dq_nxt[3]);
    sync_nxt[SYNC_LANE] = (sync_cnt == '0);
  end

  always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state      <= ST_IDLE;
      arm_cnt    <= '0;
      mode_q     <= MODE_RAMP;
      ci_q       <= '0;
      cq_q       <= '0;
      ramp_base  <= '0;
      sync_cnt   <= '0;
      beat_count <= '0;
      di_q       <= '0;
      dq_q       <= '0;
      oor_q      <= '0;
      sync_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_ARM;
            arm_cnt    <= '0;
            beat_count <= '0;
            mode_q     <= mode;
            ci_q       <= const_i;
            cq_q       <= const_q;
            ramp_base  <= '0;
            sync_cnt   <= '0;
          end
        end
        ST_ARM: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (arm_cnt == ARM_LAST) begin
            state <= ST_RUN;
          end else begin
            arm_cnt <= arm_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (beat_fire) begin
        di_q       <= di_nxt;
        dq_q       <= dq_nxt;
        oor_q      <= oor_nxt;
        sync_q     <= sync_nxt;
        valid_q    <= 1'b1;
        ramp_base  <= ramp_base + 8'd4;
        sync_cnt   <= (sync_cnt == SYNC_LAST) ? '0 : sync_cnt + 1'b1;
        beat_count <= beat_count + 32'd1;
      end else begin
        di_q    <= '0;
        dq_q    <= '0;
        oor_q   <= '0;
        sync_q  <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign user.user_datai0      = di_q[0];
  assign user.user_datai1      = di_q[1];
  assign user.user_datai2      = di_q[2];
  assign user.user_datai3      = di_q[3];
  assign user.user_dataq0      = dq_q[0];
  assign user.user_dataq1      = dq_q[1];
  assign user.user_dataq2      = dq_q[2];
  assign user.user_dataq3      = dq_q[3];
  assign user.user_outofrange0 = oor_q[0];
  assign user.user_outofrange1 = oor_q[1];
  assign user.user_sync0       = sync_q[0];
  assign user.user_sync1       = sync_q[1];
  assign user.user_sync2       = sync_q[2];
  assign user.user_sync3       = sync_q[3];
  assign user.user_data_valid  = valid_q;

endmodule
